fpadd_vec_recorder: RTL
=======================

Name: fpadd_vec_recorder

Overview:
- Hardware capture end of the fpadd test-vector flow: accepts one completed fpadd transaction per handshake (op1, op2, result, Flags) and packs it into the 200-bit test-vector record format.
- Record layout is {op1, op2, result, 3'b000, Flags}, the same format the vector files use.
- Buffers records in a small FIFO and streams each one out as seven 32-bit words, for dumping to memory or host.
- Sits beside fpadd in emulation/silicon-debug builds to regenerate .tv-style vectors.

Parameters:
- DEPTH, 4, number of 200-bit records buffered; power of 2, >= 2.
- CNT_W, 16, width of the saturating record counter.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  transaction present on op1/op2/result/flags.
- in_ready  output  1  recorder can accept a record this cycle.
- op1  input  64  fpadd operand 1.
- op2  input  64  fpadd operand 2.
- result  input  64  fpadd result.
- flags  input  5  fpadd Flags.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  32  current word of the head record.
- out_last  output  1  current word is word 0, the final word of the record.
- rec_count  output  CNT_W  records fully emitted, saturating at all-ones.

Behaviour:
- Record packing: rec[199:136]=op1, rec[135:72]=op2, rec[71:8]=result, rec[7:5]=3'b000, rec[4:0]=flags.
- Padded record is P = {24'h0, rec}, 224 bits.
- Word k = P[32k+31:32k]. Words are emitted MSW first: word 6, 5, …, 0.
- Push: occurs on a rising edge with in_valid && in_ready. in_ready = !full, registered-state derived. No pass-through, so a full FIFO being popped in the same cycle still holds in_ready=0.
- Pop: occurs when out_valid && out_ready && word_idx==0.
- Simultaneous push and pop on a non-full FIFO: both take effect; occupancy is unchanged.
- Pointers: write/read pointers are log2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH. full/empty are derived from the MSB and the low bits.
- Serializer FSM:
  - IDLE: out_valid=0, word_idx=6. Go to SEND on the cycle after FIFO becomes non-empty. Latency from push edge to first out_valid is 1 cycle.
  - SEND: out_valid=1, out_data=word[word_idx] of the head record.
    - On out_ready with word_idx>0: word_idx decrements.
    - On out_ready with word_idx==0: pop, word_idx=6, rec_count++ (saturating). Then stay in SEND if another record remains after the pop, otherwise go to IDLE.
  - out_data and out_valid stay stable while out_valid && !out_ready.
- out_last = (state==SEND) && (word_idx==0).
- Back-to-back records stream with no bubble.
- Input fields are sampled only on the push edge. Changes while !in_ready are ignored.
- Reset (asynchronous, any time, including mid-record):
  - FIFO emptied, pointers 0, state IDLE, word_idx=6, rec_count=0.
  - Outputs: out_valid=0, out_last=0, out_data=0, in_ready=1.
  - A partially emitted record is discarded; the next record after reset starts at word 6.
- rec_count holds at 2^CNT_W−1 once reached.

Test Plan:
- Single record, worked example: push op1=3FF0000000000000, op2=4000000000000000, result=4008000000000000, flags=00000, with out_ready=1.
  - Required words: 0000003F, F0000000, 00000040, 00000000, 00000040, 08000000, 00000000.
  - out_last high on the 7th word only; first out_valid 1 cycle after the push; rec_count=1.
- Flags field: same record with flags=5'b10001 -> last word 00000011; all other words unchanged.
- Fill and back-pressure: out_ready=0, push 4 distinct records.
  - in_ready drops to 0 after the 4th push; a 5th in_valid is not accepted.
  - Release out_ready: 28 words appear in push order with no gaps; in_ready returns 1 cycle after the first pop.
- Stall stability: toggle out_ready 1,0,0,1 mid-record -> out_data is held identical across the stall cycles; no word skipped or duplicated.
- Full with simultaneous pop: FIFO full, last word of the head being accepted while in_valid=1 -> that record is not accepted; it is accepted on the next cycle once in_ready=1.
- Reset mid-record: assert reset_n=0 after word 3 of a record.
  - Immediately: out_valid=0, rec_count=0, in_ready=1.
  - After release, a new push emits starting at word 6 (0000003F for the example record).

Source files
------------

// File: rtl/fpadd_vec_recorder.sv
`default_nettype none
// ============================================================================
// fpadd_vec_recorder: packs fpadd transactions into 200-bit vector records,
// buffers them and streams each as seven 32-bit words, MSW first.
// Rev 1.0
// ============================================================================
module fpadd_vec_recorder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      op1,
  input  logic [63:0]      op2,
  input  logic [63:0]      result,
  input  logic [4:0]       flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_last,
  output logic [CNT_W-1:0] rec_count
);

  localparam int         c_AW        = $clog2(DEPTH);
  localparam logic [2:0] c_LAST_WORD = 3'd6;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  logic [199:0]     r_mem [DEPTH];
  logic [c_AW:0]    r_wr_ptr;
  logic [c_AW:0]    r_rd_ptr;
  state_t           r_state;
  logic [2:0]       r_word_idx;
  logic [CNT_W-1:0] r_rec_count;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [c_AW:0]    w_wr_next;
  logic [c_AW:0]    w_rd_next;
  logic [223:0]     w_pad;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign w_push    = in_valid && !w_full;
  assign w_pop     = (r_state == S_SEND) && out_ready && (r_word_idx == 3'd0);
  assign w_wr_next = r_wr_ptr + {{c_AW{1'b0}}, w_push};
  assign w_rd_next = r_rd_ptr + {{c_AW{1'b0}}, w_pop};
  assign w_pad     = {24'h0, r_mem[r_rd_ptr[c_AW-1:0]]};

  assign in_ready  = !w_full;
  assign out_valid = (r_state == S_SEND);
  assign out_last  = (r_state == S_SEND) && (r_word_idx == 3'd0);
  assign out_data  = (r_state == S_SEND) ? w_pad[{r_word_idx, 5'b00000} +: 32] : 32'h0;
  assign rec_count = r_rec_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_AW-1:0]] <= {op1, op2, result, 3'b000, flags};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_state     <= S_IDLE;
      r_word_idx  <= c_LAST_WORD;
      r_rec_count <= '0;
    end else begin
      r_wr_ptr <= w_wr_next;
      r_rd_ptr <= w_rd_next;
      case (r_state)
        S_IDLE: begin
          r_word_idx <= c_LAST_WORD;
          if (!w_empty) begin
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          if (out_ready) begin
            if (r_word_idx == 3'd0) begin
              r_word_idx <= c_LAST_WORD;
              if (r_rec_count != {CNT_W{1'b1}}) begin
                r_rec_count <= r_rec_count + {{(CNT_W-1){1'b0}}, 1'b1};
              end
              // A record pushed on this same edge keeps the stream bubble-free.
              if (w_wr_next == w_rd_next) begin
                r_state <= S_IDLE;
              end
            end else begin
              r_word_idx <= r_word_idx - 3'd1;
            end
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_word_idx <= c_LAST_WORD;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
